// File: rtl/incr_sweep_gen_if.sv
// Bundle between the sweep control logic (master) and incr_sweep_gen (slave).
// Carries the sweep request, the increment word for the counter, and busy/done/state status.
interface incr_sweep_gen_if #(
    parameter int WIDTH       = 32,
    parameter int DWELL_WIDTH = 16
);
    // Handshake: start_i is a one-cycle request taken only while busy_o=0 and abort_i=0;
    // done_o answers it with a one-cycle pulse, abort_i ends it with no pulse.
    logic                   start_i;
    logic                   abort_i;
    logic [WIDTH-1:0]       incr_start_i;
    logic [WIDTH-1:0]       incr_stop_i;
    logic [WIDTH-1:0]       step_i;
    logic [DWELL_WIDTH-1:0] dwell_i;
    logic [WIDTH-1:0]       incr_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   state_dbg_o;

    modport master (
        output start_i, abort_i, incr_start_i, incr_stop_i, step_i, dwell_i,
        input  incr_o, busy_o, done_o, state_dbg_o
    );

    modport slave (
        input  start_i, abort_i, incr_start_i, incr_stop_i, step_i, dwell_i,
        output incr_o, busy_o, done_o, state_dbg_o
    );
endinterface

// File: rtl/incr_sweep_gen.sv
// Stepped increment sweep (chirp) generator feeding the accumulator counter's incr_i.
// Optional feature macro SWEEP_TRIANGLE_EN: sweep back to the start value after reaching stop.
module incr_sweep_gen #(
    parameter int WIDTH       = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    incr_sweep_gen_if.slave   sif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       incr_q, incr_d;
    logic [WIDTH-1:0]       tgt_q, tgt_d;
    logic [WIDTH-1:0]       step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic                   up_q, up_d;
    logic                   done_q, done_d;
`ifdef SWEEP_TRIANGLE_EN
    logic [WIDTH-1:0]       start_q, start_d;
    logic                   leg_q, leg_d;
`endif

    logic [WIDTH-1:0]       eff_tgt;
    logic                   eff_up;
    logic                   at_end;
    logic                   turn;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       next_val;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            incr_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
            start_q <= '0;
            leg_q   <= 1'b0;
`endif
        end else begin
            incr_q  <= incr_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            done_q  <= done_d;
`ifdef SWEEP_TRIANGLE_EN
            start_q <= start_d;
            leg_q   <= leg_d;
`endif
        end
    end

    // Next increment toward the current leg's target; the gap is clamped so it never overshoots or wraps.
    always_comb begin
        eff_tgt = tgt_q;
        eff_up  = up_q;
        at_end  = (incr_q == tgt_q);
        turn    = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
        if (at_end && !leg_q && (start_q != tgt_q)) begin
            turn    = 1'b1;
            at_end  = 1'b0;
            eff_tgt = start_q;
            eff_up  = ~up_q;
        end
`endif
        diff = eff_up ? (eff_tgt - incr_q) : (incr_q - eff_tgt);
        if ((step_q == '0) || (diff <= step_q)) begin
            next_val = eff_tgt;
        end else if (eff_up) begin
            next_val = incr_q + step_q;
        end else begin
            next_val = incr_q - step_q;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        incr_d  = incr_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        up_d    = up_q;
        done_d  = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
        start_d = start_q;
        leg_d   = leg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sif.start_i && !sif.abort_i) begin
                    state_d = S_DWELL;
                    incr_d  = sif.incr_start_i;
                    tgt_d   = sif.incr_stop_i;
                    step_d  = sif.step_i;
                    dwell_d = sif.dwell_i;
                    cnt_d   = sif.dwell_i;
                    up_d    = (sif.incr_stop_i >= sif.incr_start_i);
`ifdef SWEEP_TRIANGLE_EN
                    start_d = sif.incr_start_i;
                    leg_d   = 1'b0;
`endif
                end
            end
            S_DWELL: begin
                if (sif.abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (at_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    incr_d = next_val;
                    cnt_d  = dwell_q;
`ifdef SWEEP_TRIANGLE_EN
                    if (turn) begin
                        tgt_d = start_q;
                        up_d  = ~up_q;
                        leg_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        sif.incr_o      = incr_q;
        sif.busy_o      = (state_q == S_DWELL);
        sif.done_o      = done_q;
        sif.state_dbg_o = state_q;
    end

endmodule

// File: tb/tb_incr_sweep_gen.sv
// Directed bench for incr_sweep_gen: hand-computed increment sequences checked each cycle.
// Follows SWEEP_TRIANGLE_EN so the same bench covers both builds.
module tb_incr_sweep_gen;

  localparam int W  = 32;
  localparam int DW = 16;

  logic clk;
  logic reset;

  int chk_cnt;
  int pass_cnt;

  logic [W-1:0] exp_q[$];

  incr_sweep_gen_if #(.WIDTH(W), .DWELL_WIDTH(DW)) sif ();

  incr_sweep_gen #(.WIDTH(W), .DWELL_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // called at a negedge; returns one negedge later with the first value visible
  task automatic start_sweep(input logic [W-1:0] s, input logic [W-1:0] e,
                             input logic [W-1:0] st, input logic [DW-1:0] dw);
    sif.start_i      = 1'b1;
    sif.incr_start_i = s;
    sif.incr_stop_i  = e;
    sif.step_i       = st;
    sif.dwell_i      = dw;
    @(negedge clk);
    sif.start_i = 1'b0;
  endtask

  // in the triangle build a symmetric sweep retraces its values back to the start
  task automatic mirror_q();
`ifdef SWEEP_TRIANGLE_EN
    for (int i = exp_q.size() - 2; i >= 0; i--) exp_q.push_back(exp_q[i]);
`endif
  endtask

  task automatic expect_sweep(input int dw);
    logic [W-1:0] v;
    v = '0;
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      for (int i = 0; i <= dw; i++) begin
        check("incr", sif.incr_o, v);
        check("busy", {31'd0, sif.busy_o}, 1);
        check("done_early", {31'd0, sif.done_o}, 0);
        @(negedge clk);
      end
    end
    check("done_pulse", {31'd0, sif.done_o}, 1);
    check("busy_at_done", {31'd0, sif.busy_o}, 0);
    check("hold_final", sif.incr_o, v);
    @(negedge clk);
    check("done_one_cycle", {31'd0, sif.done_o}, 0);
    check("hold_after_done", sif.incr_o, v);
  endtask

  initial begin
    logic [W-1:0] v;
    chk_cnt  = 0;
    pass_cnt = 0;
    reset = 1'b1;
    sif.start_i = 1'b0;
    sif.abort_i = 1'b0;
    sif.incr_start_i = '0;
    sif.incr_stop_i  = '0;
    sif.step_i       = '0;
    sif.dwell_i      = '0;
    repeat (2) @(negedge clk);
    check("rst_incr", sif.incr_o, 0);
    check("rst_busy", {31'd0, sif.busy_o}, 0);
    check("rst_done", {31'd0, sif.done_o}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, sif.busy_o}, 0);

    // 1: up sweep, dwell 0
    exp_q = {32'd2, 32'd4, 32'd6, 32'd8, 32'd10};
    mirror_q();
    start_sweep(2, 10, 2, 0);
    expect_sweep(0);

    // 2: down sweep with clamped final step, dwell 1
`ifdef SWEEP_TRIANGLE_EN
    exp_q = {32'd20, 32'd16, 32'd12, 32'd8, 32'd5, 32'd9, 32'd13, 32'd17, 32'd20};
`else
    exp_q = {32'd20, 32'd16, 32'd12, 32'd8, 32'd5};
`endif
    start_sweep(20, 5, 4, 1);
    expect_sweep(1);

    // 3: abort at value 30
    start_sweep(0, 100, 10, 3);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        check("abort_pre_incr", sif.incr_o, 32'(k * 10));
        @(negedge clk);
      end
    end
    check("abort_at_30", sif.incr_o, 30);
    sif.abort_i = 1'b1;
    @(negedge clk);
    sif.abort_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("abort_busy", {31'd0, sif.busy_o}, 0);
      check("abort_done", {31'd0, sif.done_o}, 0);
      check("abort_hold", sif.incr_o, 30);
      @(negedge clk);
    end

    // start together with abort in IDLE is ignored
    sif.abort_i = 1'b1;
    start_sweep(50, 60, 1, 0);
    sif.abort_i = 1'b0;
    check("start_abort_busy", {31'd0, sif.busy_o}, 0);
    check("start_abort_incr", sif.incr_o, 30);

    // 4: re-pulsed start with new inputs mid-sweep is ignored
    exp_q = {32'd2, 32'd4, 32'd6, 32'd8, 32'd10};
    mirror_q();
    start_sweep(2, 10, 2, 1);
    for (int k = 0; k < 2; k++) begin
      v = exp_q.pop_front();
      for (int i = 0; i < 2; i++) begin
        check("restart_incr", sif.incr_o, v);
        if (k == 1 && i == 0) begin
          sif.start_i      = 1'b1;
          sif.incr_start_i = 77;
          sif.incr_stop_i  = 0;
          sif.step_i       = 5;
          sif.dwell_i      = 0;
        end else begin
          sif.start_i = 1'b0;
        end
        @(negedge clk);
      end
    end
    expect_sweep(1);

    // step 0 jumps straight to stop
    exp_q = {32'd3, 32'd9};
    mirror_q();
    start_sweep(3, 9, 0, 0);
    expect_sweep(0);

    // start == stop: held dwell+1 cycles then done
    exp_q = {32'd7};
    start_sweep(7, 7, 5, 2);
    expect_sweep(2);

    // 5: reset mid-sweep at value 40
    start_sweep(0, 100, 10, 0);
    for (int k = 0; k < 4; k++) begin
      check("pre_reset_incr", sif.incr_o, 32'(k * 10));
      @(negedge clk);
    end
    check("pre_reset_40", sif.incr_o, 40);
    reset = 1'b1;
    #1;
    check("mid_rst_incr", sif.incr_o, 0);
    check("mid_rst_busy", {31'd0, sif.busy_o}, 0);
    check("mid_rst_done", {31'd0, sif.done_o}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q = {32'd2, 32'd4, 32'd6, 32'd8, 32'd10};
    mirror_q();
    start_sweep(2, 10, 2, 0);
    expect_sweep(0);

    // 6: short sweep (triangle 2,4,6,4,2 / one-way 2,4,6)
    exp_q = {32'd2, 32'd4, 32'd6};
    mirror_q();
    start_sweep(2, 6, 2, 0);
    expect_sweep(0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
